// File: rtl/ascii_to_scancode.sv
// ascii_to_scancode: turns one ASCII character into the PS/2 Set-2 byte stream a
// US keyboard would send for it (make, break prefix, make, with a left-shift wrap
// for shifted characters). Bytes leave on a valid/ready handshake, optionally
// separated by a fixed number of idle clocks.
module ascii_to_scancode #(
  parameter logic [7:0] SHIFT_CODE   = 8'h12,
  parameter logic [7:0] BREAK_PREFIX = 8'hF0,
  parameter int         GAP_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       unmapped
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SH_MK   = 3'd1,
    MK      = 3'd2,
    BRK     = 3'd3,
    MK2     = 3'd4,
    SH_BRK  = 3'd5,
    SH_CODE = 3'd6
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  // Character lookup: result is {mapped, shifted, make_code}.
  function automatic logic [9:0] map_char(input logic [7:0] c);
    logic [9:0] r;
    case (c)
      8'h61: r = {2'b10, 8'h1C};  8'h62: r = {2'b10, 8'h32};  8'h63: r = {2'b10, 8'h21};
      8'h64: r = {2'b10, 8'h23};  8'h65: r = {2'b10, 8'h24};  8'h66: r = {2'b10, 8'h2B};
      8'h67: r = {2'b10, 8'h34};  8'h68: r = {2'b10, 8'h33};  8'h69: r = {2'b10, 8'h43};
      8'h6A: r = {2'b10, 8'h3B};  8'h6B: r = {2'b10, 8'h42};  8'h6C: r = {2'b10, 8'h4B};
      8'h6D: r = {2'b10, 8'h3A};  8'h6E: r = {2'b10, 8'h31};  8'h6F: r = {2'b10, 8'h44};
      8'h70: r = {2'b10, 8'h4D};  8'h71: r = {2'b10, 8'h15};  8'h72: r = {2'b10, 8'h2D};
      8'h73: r = {2'b10, 8'h1B};  8'h74: r = {2'b10, 8'h2C};  8'h75: r = {2'b10, 8'h3C};
      8'h76: r = {2'b10, 8'h2A};  8'h77: r = {2'b10, 8'h1D};  8'h78: r = {2'b10, 8'h22};
      8'h79: r = {2'b10, 8'h35};  8'h7A: r = {2'b10, 8'h1A};
      8'h41: r = {2'b11, 8'h1C};  8'h42: r = {2'b11, 8'h32};  8'h43: r = {2'b11, 8'h21};
      8'h44: r = {2'b11, 8'h23};  8'h45: r = {2'b11, 8'h24};  8'h46: r = {2'b11, 8'h2B};
      8'h47: r = {2'b11, 8'h34};  8'h48: r = {2'b11, 8'h33};  8'h49: r = {2'b11, 8'h43};
      8'h4A: r = {2'b11, 8'h3B};  8'h4B: r = {2'b11, 8'h42};  8'h4C: r = {2'b11, 8'h4B};
      8'h4D: r = {2'b11, 8'h3A};  8'h4E: r = {2'b11, 8'h31};  8'h4F: r = {2'b11, 8'h44};
      8'h50: r = {2'b11, 8'h4D};  8'h51: r = {2'b11, 8'h15};  8'h52: r = {2'b11, 8'h2D};
      8'h53: r = {2'b11, 8'h1B};  8'h54: r = {2'b11, 8'h2C};  8'h55: r = {2'b11, 8'h3C};
      8'h56: r = {2'b11, 8'h2A};  8'h57: r = {2'b11, 8'h1D};  8'h58: r = {2'b11, 8'h22};
      8'h59: r = {2'b11, 8'h35};  8'h5A: r = {2'b11, 8'h1A};
      8'h30: r = {2'b10, 8'h45};  8'h31: r = {2'b10, 8'h16};  8'h32: r = {2'b10, 8'h1E};
      8'h33: r = {2'b10, 8'h26};  8'h34: r = {2'b10, 8'h25};  8'h35: r = {2'b10, 8'h2E};
      8'h36: r = {2'b10, 8'h36};  8'h37: r = {2'b10, 8'h3D};  8'h38: r = {2'b10, 8'h3E};
      8'h39: r = {2'b10, 8'h46};
      8'h20: r = {2'b10, 8'h29};  8'h0D: r = {2'b10, 8'h5A};  8'h08: r = {2'b10, 8'h66};
      8'h2D: r = {2'b10, 8'h4E};  8'h3D: r = {2'b10, 8'h55};  8'h2C: r = {2'b10, 8'h41};
      8'h2E: r = {2'b10, 8'h49};  8'h2F: r = {2'b10, 8'h4A};  8'h3B: r = {2'b10, 8'h4C};
      8'h27: r = {2'b10, 8'h52};
      // shifted digit row: ! @ # $ % ^ & * ( )
      8'h21: r = {2'b11, 8'h16};  8'h40: r = {2'b11, 8'h1E};  8'h23: r = {2'b11, 8'h26};
      8'h24: r = {2'b11, 8'h25};  8'h25: r = {2'b11, 8'h2E};  8'h5E: r = {2'b11, 8'h36};
      8'h26: r = {2'b11, 8'h3D};  8'h2A: r = {2'b11, 8'h3E};  8'h28: r = {2'b11, 8'h46};
      8'h29: r = {2'b11, 8'h45};
      // shifted punctuation: _ + < > ? : "
      8'h5F: r = {2'b11, 8'h4E};  8'h2B: r = {2'b11, 8'h55};  8'h3C: r = {2'b11, 8'h41};
      8'h3E: r = {2'b11, 8'h49};  8'h3F: r = {2'b11, 8'h4A};  8'h3A: r = {2'b11, 8'h4C};
      8'h22: r = {2'b11, 8'h52};
      default: r = {2'b00, 8'h00};
    endcase
    return r;
  endfunction

  // Byte presented while the FSM sits in a given state.
  function automatic logic [7:0] byte_for(input state_t st, input logic [7:0] mk);
    logic [7:0] b;
    case (st)
      SH_MK, SH_CODE: b = SHIFT_CODE;
      MK, MK2:        b = mk;
      BRK, SH_BRK:    b = BREAK_PREFIX;
      default:        b = 8'h00;
    endcase
    return b;
  endfunction

  state_t     state_r, state_s, succ_s;
  logic [7:0] code_out_r, code_out_s;
  logic       code_valid_r, code_valid_s;
  logic       busy_r, busy_s;
  logic       ready_r, ready_s;
  logic       unmapped_r, unmapped_s;
  logic [7:0] gap_r, gap_s;
  logic [7:0] make_r, make_s;
  logic       shifted_r, shifted_s;
  logic       advance_s;
  logic [9:0] map_s;

  // Next-state and next-output computation for the encoder FSM.
  always_comb begin
    state_s      = state_r;
    code_out_s   = code_out_r;
    code_valid_s = code_valid_r;
    busy_s       = busy_r;
    ready_s      = ready_r;
    unmapped_s   = 1'b0;
    gap_s        = gap_r;
    make_s       = make_r;
    shifted_s    = shifted_r;
    advance_s    = 1'b0;
    map_s        = map_char(ascii_in);

    case (state_r)
      SH_MK:   succ_s = MK;
      MK:      succ_s = BRK;
      BRK:     succ_s = MK2;
      MK2:     succ_s = shifted_r ? SH_BRK : IDLE;
      SH_BRK:  succ_s = SH_CODE;
      SH_CODE: succ_s = IDLE;
      default: succ_s = IDLE;
    endcase

    if (state_r == IDLE) begin
      if (ascii_valid && ready_r) begin
        ready_s = 1'b0;
        if (map_s[9]) begin
          shifted_s    = map_s[8];
          make_s       = map_s[7:0];
          state_s      = map_s[8] ? SH_MK : MK;
          code_out_s   = map_s[8] ? SHIFT_CODE : map_s[7:0];
          code_valid_s = 1'b1;
          busy_s       = 1'b1;
        end else begin
          // unmapped: one-cycle pulse, ready drops for that cycle only
          unmapped_s = 1'b1;
        end
      end else begin
        ready_s = 1'b1;
      end
    end else if (gap_r != 8'd0) begin
      // idle spacing after a handshake; the move on happens as it expires
      gap_s     = gap_r - 8'd1;
      advance_s = (gap_r == 8'd1);
    end else if (code_valid_r && code_ready) begin
      if (GAP_LOAD != 8'd0) begin
        code_valid_s = 1'b0;
        gap_s        = GAP_LOAD;
      end else begin
        advance_s = 1'b1;
      end
    end else begin
      // stalled: hold code_out/code_valid unchanged
      state_s = state_r;
    end

    if (advance_s) begin
      state_s = succ_s;
      if (succ_s == IDLE) begin
        code_valid_s = 1'b0;
        busy_s       = 1'b0;
        ready_s      = 1'b1;
      end else begin
        code_valid_s = 1'b1;
        code_out_s   = byte_for(succ_s, make_r);
      end
    end else begin
      advance_s = 1'b0;
    end
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      code_out_r   <= 8'h00;
      code_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b0;
      unmapped_r   <= 1'b0;
      gap_r        <= 8'd0;
      make_r       <= 8'h00;
      shifted_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      code_out_r   <= code_out_s;
      code_valid_r <= code_valid_s;
      busy_r       <= busy_s;
      ready_r      <= ready_s;
      unmapped_r   <= unmapped_s;
      gap_r        <= gap_s;
      make_r       <= make_s;
      shifted_r    <= shifted_s;
    end
  end

  assign ascii_ready = ready_r;
  assign code_out    = code_out_r;
  assign code_valid  = code_valid_r;
  assign busy        = busy_r;
  assign unmapped    = unmapped_r;

endmodule

// File: tb/tb_ascii_to_scancode.sv
// Bench for ascii_to_scancode: two instances (no gap, gap of 3) sharing clock and
// reset; random characters and random downstream readiness checked against a
// keyboard-table model and a scan-code decoder model.
module tb_ascii_to_scancode;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       code_ready;
  logic       sel;

  logic       av0, ar0, cv0, busy0, unm0;
  logic [7:0] co0;
  logic       av1, ar1, cv1, busy1, unm1;
  logic [7:0] co1;

  assign av0 = ascii_valid & ~sel;
  assign av1 = ascii_valid & sel;

  wire       o_ar   = sel ? ar1 : ar0;
  wire       o_cv   = sel ? cv1 : cv0;
  wire       o_busy = sel ? busy1 : busy0;
  wire       o_unm  = sel ? unm1 : unm0;
  wire [7:0] o_co   = sel ? co1 : co0;

  ascii_to_scancode #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .ascii_in(ascii_in), .ascii_valid(av0), .ascii_ready(ar0),
    .code_out(co0), .code_valid(cv0), .code_ready(code_ready), .busy(busy0), .unmapped(unm0));

  ascii_to_scancode #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .ascii_in(ascii_in), .ascii_valid(av1), .ascii_ready(ar1),
    .code_out(co1), .code_valid(cv1), .code_ready(code_ready), .busy(busy1), .unmapped(unm1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int gaps_q[$];
  int busy_cycles;
  int trail;
  bit saw_unm;

  logic [7:0] letter_tab[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_tab[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  logic [7:0] pun_c[7] = '{8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A, 8'h4C, 8'h52};
  string pun_u = "-=,./;'";
  string pun_s = "_+<>?:\"";
  string dig_s = ")!@#$%^&*(";

  // US keyboard reference: which key a character needs and whether shift is held.
  function automatic void model(input logic [7:0] c, output bit m, output bit sh,
                                output logic [7:0] mk);
    m = 1'b1; sh = 1'b0; mk = 8'h00;
    if (c >= 8'h61 && c <= 8'h7A) mk = letter_tab[int'(c) - 97];
    else if (c >= 8'h41 && c <= 8'h5A) begin sh = 1'b1; mk = letter_tab[int'(c) - 65]; end
    else if (c >= 8'h30 && c <= 8'h39) mk = digit_tab[int'(c) - 48];
    else if (c == 8'h20) mk = 8'h29;
    else if (c == 8'h0D) mk = 8'h5A;
    else if (c == 8'h08) mk = 8'h66;
    else begin
      m = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (c == pun_u[i]) begin m = 1'b1; mk = pun_c[i]; end
        if (c == pun_s[i]) begin m = 1'b1; sh = 1'b1; mk = pun_c[i]; end
      end
      for (int i = 0; i < 10; i++)
        if (c == dig_s[i]) begin m = 1'b1; sh = 1'b1; mk = digit_tab[i]; end
    end
  endfunction

  // Scan-code-to-ASCII decoder model: tracks shift and break state over got_q.
  task automatic decode_stream(output bit shift_left);
    bit shift, brk, found, m, sh;
    logic [7:0] mk;
    shift = 1'b0; brk = 1'b0;
    dec_q.delete();
    foreach (got_q[i]) begin
      if (got_q[i] == 8'hF0) brk = 1'b1;
      else if (got_q[i] == 8'h12) begin shift = !brk; brk = 1'b0; end
      else begin
        if (!brk) begin
          found = 1'b0;
          for (int x = 0; x < 128; x++) begin
            model(8'(x), m, sh, mk);
            if (!found && m && mk == got_q[i] && sh == shift) begin
              dec_q.push_back(8'(x)); found = 1'b1;
            end
          end
          if (!found) dec_q.push_back(8'hFF);
        end
        brk = 1'b0;
      end
    end
    shift_left = shift | brk;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [7:0] c, output bit ok);
    int n;
    n = 0;
    while (!o_ar && n < 50) begin tick(); n++; end
    ok = o_ar;
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_wait char=%02h got ready=0 exp 1", c); end
    else begin
      ascii_in = c; ascii_valid = 1'b1;
      tick();
      ascii_valid = 1'b0; ascii_in = 8'($urandom);
    end
  endtask

  // Drain one sequence, recording handshaked bytes and the idle run before each.
  task automatic collect(input int st_at, input int st_len, input bit rnd);
    bit held, cr;
    logic [7:0] held_v;
    int lowrun, n, st;
    got_q.delete(); gaps_q.delete();
    held = 1'b0; held_v = 8'h00; lowrun = 0; n = 0; st = 0; busy_cycles = 0; saw_unm = 1'b0;
    while (o_busy && n < 400) begin
      busy_cycles++; n++;
      if (o_unm) saw_unm = 1'b1;
      if (held) begin
        checks++;
        if (o_cv !== 1'b1 || o_co !== held_v) begin
          failures++;
          $display("FAIL hold_stable got=%02h/%0b exp=%02h/1", o_co, o_cv, held_v);
        end
      end
      if (o_cv) begin
        if (got_q.size() == st_at && st < st_len) begin cr = 1'b0; st++; end
        else if (rnd) cr = 1'($urandom_range(0, 1));
        else cr = 1'b1;
        code_ready = cr;
        if (cr) begin got_q.push_back(o_co); gaps_q.push_back(lowrun); lowrun = 0; held = 1'b0; end
        else begin held = 1'b1; held_v = o_co; end
      end else begin
        lowrun++;
        code_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rnd) begin ascii_valid = 1'($urandom_range(0, 1)); ascii_in = 8'($urandom); end
      tick();
    end
    ascii_valid = 1'b0; code_ready = 1'b1;
    trail = lowrun;
    checks++;
    if (o_busy) begin failures++; $display("FAIL seq_timeout got busy=1 exp 0"); end
  endtask

  task automatic run_char(input logic [7:0] c, input int gap, input bit rnd,
                          input int st_at, input int st_len);
    bit ok, m, sh, left;
    logic [7:0] mk;
    bit gap_ok;
    model(c, m, sh, mk);
    accept(c, ok);
    if (ok) begin
      if (!m) begin
        checks++;
        if (o_unm !== 1'b1 || o_ar !== 1'b0 || o_cv !== 1'b0 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL unmapped_pulse char=%02h got unm=%0b rdy=%0b cv=%0b busy=%0b exp 1 0 0 0",
                   c, o_unm, o_ar, o_cv, o_busy);
        end
        tick();
        checks++;
        if (o_unm !== 1'b0 || o_ar !== 1'b1 || o_cv !== 1'b0) begin
          failures++;
          $display("FAIL unmapped_recover char=%02h got unm=%0b rdy=%0b cv=%0b exp 0 1 0",
                   c, o_unm, o_ar, o_cv);
        end
      end else begin
        collect(st_at, st_len, rnd);
        exp_q.delete();
        if (sh) exp_q.push_back(8'h12);
        exp_q.push_back(mk); exp_q.push_back(8'hF0); exp_q.push_back(mk);
        if (sh) begin exp_q.push_back(8'hF0); exp_q.push_back(8'h12); end
        checks++;
        if (got_q != exp_q) begin
          failures++;
          $display("FAIL stream char=%02h got=%p exp=%p", c, got_q, exp_q);
        end
        gap_ok = (trail == gap);
        foreach (gaps_q[i]) if (gaps_q[i] != ((i == 0) ? 0 : gap)) gap_ok = 1'b0;
        checks++;
        if (!gap_ok) begin
          failures++;
          $display("FAIL gap char=%02h got=%p trail=%0d exp gap %0d", c, gaps_q, trail, gap);
        end
        checks++;
        if (o_ar !== 1'b1 || saw_unm) begin
          failures++;
          $display("FAIL ready_after char=%02h got rdy=%0b unm_seen=%0b exp 1 0", c, o_ar, saw_unm);
        end
        if (!rnd && st_len == 0) begin
          checks++;
          if (busy_cycles != exp_q.size() * (1 + gap)) begin
            failures++;
            $display("FAIL throughput char=%02h got=%0d exp=%0d", c, busy_cycles,
                     exp_q.size() * (1 + gap));
          end
        end
        decode_stream(left);
        checks++;
        if (dec_q.size() != 1 || dec_q[0] != c || left) begin
          failures++;
          $display("FAIL decode char=%02h got=%p exp single char", c, dec_q);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; #1 rst = 1'b1;
    tick();
    checks++;
    if ({co0, cv0, busy0, unm0, ar0, co1, cv1, busy1, unm1, ar1} !== 26'd0) begin
      failures++;
      $display("FAIL reset_state got=%07h exp=0", {co0, cv0, busy0, unm0, ar0, co1, cv1, busy1, unm1, ar1});
    end
    rst = 1'b0;
    checks++;
    if (ar0 !== 1'b0) begin failures++; $display("FAIL ready_release got=%0b exp 0", ar0); end
    tick();
    checks++;
    if (ar0 !== 1'b1 || ar1 !== 1'b1) begin
      failures++; $display("FAIL ready_rise got=%0b%0b exp 11", ar0, ar1);
    end
  endtask

  task automatic test_basic();
    run_char(8'h61, 0, 1'b0, -1, 0);
    run_char(8'h41, 0, 1'b0, -1, 0);
    run_char(8'h21, 0, 1'b0, -1, 0);
    run_char(8'h0D, 0, 1'b0, -1, 0);
  endtask

  task automatic test_unmapped();
    run_char(8'h7E, 0, 1'b0, -1, 0);
    run_char(8'h80, 0, 1'b0, -1, 0);
    run_char(8'h00, 0, 1'b0, -1, 0);
    run_char(8'($urandom_range(128, 255)), 0, 1'b0, -1, 0);
  endtask

  task automatic test_stall();
    run_char(8'h7A, 0, 1'b0, 1, 5);
    run_char(8'h51, 0, 1'b0, 3, 7);
  endtask

  task automatic test_gap();
    sel = 1'b1;
    run_char(8'h31, 3, 1'b0, -1, 0);
    run_char(8'h3F, 3, 1'b0, -1, 0);
    for (int i = 0; i < 6; i++)
      run_char(8'($urandom_range(0, 127)), 3, 1'b1, $urandom_range(0, 5), $urandom_range(0, 4));
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    accept(8'h51, ok);
    code_ready = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({co0, cv0, busy0, unm0, ar0} !== 12'd0) begin
      failures++; $display("FAIL reset_mid got=%03h exp=000", {co0, cv0, busy0, unm0, ar0});
    end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    checks++;
    if (cv0 !== 1'b0 || busy0 !== 1'b0 || ar0 !== 1'b1) begin
      failures++; $display("FAIL no_resume got cv=%0b busy=%0b rdy=%0b exp 0 0 1", cv0, busy0, ar0);
    end
    run_char(8'h62, 0, 1'b0, -1, 0);
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 128; c++)
      run_char(8'(c), 0, 1'b1, $urandom_range(0, 5), $urandom_range(0, 4));
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++)
      run_char(8'($urandom_range(0, 255)), 0, 1'b0, -1, 0);
  endtask

  initial begin
    sel = 1'b0; ascii_in = 8'h00; ascii_valid = 1'b0; code_ready = 1'b1;
    test_reset();
    test_basic();
    test_unmapped();
    test_stall();
    test_gap();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
